// File: rtl/stream_fifo_if.sv
// Handshake bundle between a stream producer/consumer pair and stream_fifo.
// Write side, read side and status flags share one interface.
interface stream_fifo_if #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             flush;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [AW:0]      count;
  logic             full;
  logic             almost_full;
  logic             overflow;

  modport master (
    output flush, in, in_valid, out_ready,
    input  in_ready, out, out_valid, out_last, count, full, almost_full, overflow
  );

  modport slave (
    input  flush, in, in_valid, out_ready,
    output in_ready, out, out_valid, out_last, count, full, almost_full, overflow
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO for coefficient streams, with backpressure,
// occupancy count, almost-full flag, synchronous flush and sticky overflow.
module stream_fifo #(
  parameter int WIDTH        = 13,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic          clk,
  input  logic          resetn,
  stream_fifo_if.slave  bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.in_valid & full);
    if (bus.flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + ONE;
      if (pop)  rp_d = rp_q + ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem_q[wp_q[AW-1:0]] <= bus.in;
  end

  assign bus.in_ready    = !full;
  assign bus.out         = mem_q[rp_q[AW-1:0]];
  assign bus.out_valid   = !empty;
  assign bus.out_last    = (count_q == ONE);
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.almost_full = (count_q >= AFULL_C);
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_stream_fifo.sv
// Directed-vector and scoreboard bench for stream_fifo (WIDTH=13, DEPTH=16).
module tb_stream_fifo;
  localparam int W = 13;
  localparam int D = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  stream_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  stream_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(14)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit inv_en   = 1'b0;

  typedef struct {
    logic         rstn, fl, iv, ordy;
    logic [W-1:0] din;
    logic [4:0]   e_count;
    logic         e_ovalid, e_full, e_af, e_last, e_ovf, chk_out;
    logic [W-1:0] e_out;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic fl, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
    resetn        = rn;
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in        = d;
    bus.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int rstn, input int fl, input int iv, input int din,
                              input int ordy, input int cnt, input int ovalid, input int full,
                              input int af, input int last, input int ovf, input int chko,
                              input int eout);
    vec_t v;
    v.rstn = rstn[0];  v.fl = fl[0];  v.iv = iv[0];  v.ordy = ordy[0];
    v.din = W'(din);   v.e_count = 5'(cnt);
    v.e_ovalid = ovalid[0]; v.e_full = full[0]; v.e_af = af[0]; v.e_last = last[0];
    v.e_ovf = ovf[0];  v.chk_out = chko[0];   v.e_out = W'(eout);
    return v;
  endfunction

  // Structural invariants, checked on the falling edge once out of reset.
  always @(negedge clk) begin
    logic [4:0] diff;
    if (inv_en) begin
      diff = dut.wp_q - dut.rp_q;
      chk("inv_count_eq_ptrdiff", 32'(dut.count_q), 32'(diff));
      chk("inv_full_not_ready", 32'(bus.full & bus.in_ready), 32'd0);
      chk("inv_empty_count0", 32'(!bus.out_valid && (bus.count != 5'd0)), 32'd0);
    end
  end

  initial begin
    logic [W-1:0] sb[$];
    logic         ovf_m;
    logic         iv, ordy, pu, po;
    logic [W-1:0] d;
    int           bias;

    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Reset, fill 0x000..0x00F, drain: all expectations hand-tabulated.
    tv.push_back(mk(0,0,0,0,0, 0, 0,0,0,0,0, 0,0));
    for (int n = 0; n < 16; n++)
      tv.push_back(mk(1,0,1,n,0, n+1, 1, int'(n+1 == 16), int'(n+1 >= 14), int'(n+1 == 1), 0, 1, 0));
    for (int k = 0; k < 16; k++)
      tv.push_back(mk(1,0,0,0,1, 15-k, int'(k != 15), 0, int'(15-k >= 14), int'(15-k == 1),
                      0, int'(k != 15), k+1));

    foreach (tv[i]) begin
      drive(tv[i].rstn, tv[i].fl, tv[i].iv, tv[i].din, tv[i].ordy);
      step();
      inv_en = 1'b1;
      chk($sformatf("v%0d_count", i),     32'(bus.count),       32'(tv[i].e_count));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid),   32'(tv[i].e_ovalid));
      chk($sformatf("v%0d_full", i),      32'(bus.full),        32'(tv[i].e_full));
      chk($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),    32'(!tv[i].e_full));
      chk($sformatf("v%0d_afull", i),     32'(bus.almost_full), 32'(tv[i].e_af));
      chk($sformatf("v%0d_last", i),      32'(bus.out_last),    32'(tv[i].e_last));
      chk($sformatf("v%0d_overflow", i),  32'(bus.overflow),    32'(tv[i].e_ovf));
      if (tv[i].chk_out) chk($sformatf("v%0d_out", i), 32'(bus.out), 32'(tv[i].e_out));
    end

    // Preload three words, then stream 100 more with push and pop every cycle.
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1'b0, 1'b1, W'(13'h1000 + n), 1'b0);
      step();
    end
    for (int i = 0; i < 100; i++) begin
      chk("stream_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_out", 32'(bus.out), 32'(13'h1000 + i));
      drive(1'b1, 1'b0, 1'b1, W'(13'h1000 + i + 3), 1'b1);
      step();
      chk("stream_count", 32'(bus.count), 32'd3);
    end
    for (int i = 100; i < 103; i++) begin
      chk("stream_tail_out", 32'(bus.out), 32'(13'h1000 + i));
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      step();
    end
    chk("stream_empty", 32'(bus.out_valid), 32'd0);

    // Rejected write while full and popping: dropped, overflow sticky through flush.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0); step();
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 1'b0, 1'b1, W'(13'h0100 + n), 1'b0);
      step();
    end
    chk("ovf_full", 32'(bus.full), 32'd1);
    chk("ovf_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 13'h1FFF, 1'b1);
    step();
    chk("ovf_count", 32'(bus.count), 32'd15);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_in_ready_back", 32'(bus.in_ready), 32'd1);
    for (int k = 1; k < 16; k++) begin
      chk("ovf_drain_out", 32'(bus.out), 32'(13'h0100 + k));
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      step();
    end
    chk("ovf_drained", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0); step();
    chk("ovf_after_flush", 32'(bus.overflow), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0); step();
    chk("ovf_after_reset", 32'(bus.overflow), 32'd0);

    // Flush beats a simultaneous push and pop.
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b0, 1'b1, W'(13'h0200 + n), 1'b0);
      step();
    end
    chk("fl_pre_count", 32'(bus.count), 32'd5);
    drive(1'b1, 1'b1, 1'b1, 13'h0555, 1'b1);
    step();
    chk("fl_count", 32'(bus.count), 32'd0);
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 13'h0ABC, 1'b0);
    step();
    chk("fl_push_out", 32'(bus.out), 32'h0ABC);
    chk("fl_push_last", 32'(bus.out_last), 32'd1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1); step();

    // Push on empty with out_ready high: no pop that cycle.
    chk("emp_pre_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 13'h0123, 1'b1);
    step();
    chk("emp_count", 32'(bus.count), 32'd1);
    chk("emp_valid", 32'(bus.out_valid), 32'd1);
    chk("emp_out", 32'(bus.out), 32'h0123);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step();
    chk("emp_popped", 32'(bus.count), 32'd0);

    // Random traffic against a scoreboard queue, alternating fill/drain bias.
    ovf_m = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      chk("rnd_count", 32'(bus.count), 32'(sb.size()));
      chk("rnd_afull", 32'(bus.almost_full), 32'(sb.size() >= 14));
      if (sb.size() != 0) chk("rnd_out", 32'(bus.out), 32'(sb[0]));
      bias = ((c / 500) % 2 == 1) ? 30 : 75;
      iv   = ($urandom_range(0, 99) < bias);
      ordy = ($urandom_range(0, 99) < (100 - bias));
      d    = W'($urandom_range(0, 8191));
      pu   = iv && (sb.size() < D);
      po   = ordy && (sb.size() > 0);
      if (iv && sb.size() == D) ovf_m = 1'b1;
      drive(1'b1, 1'b0, iv, d, ordy);
      step();
      if (po) void'(sb.pop_front());
      if (pu) sb.push_back(d);
    end
    chk("rnd_overflow", 32'(bus.overflow), 32'(ovf_m));

    inv_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised first-word-fall-through FIFO for coefficient streams between the NTT datapath stages and the memory/IO units. It generalises the team's fixed 13-bit × 16 buffer with several additions: configurable width and depth, real input backpressure (`in_ready`/`full`), an occupancy count, a programmable almost-full flag, a synchronous flush, and a sticky overflow error. Producers that ignore `in_ready` are detected rather than silently corrupting data.

## Interface
- `WIDTH`, default 13: data width in bits.
- `DEPTH`, default 16: number of entries. Must be a power of two, ≥ 2.
- `AFULL_THRESH`, default `DEPTH-2`: `almost_full` asserts when count ≥ this value. Range 1..`DEPTH`.
- `AW`, localparam = `$clog2(DEPTH)`: pointer index width. Pointers and count are `AW+1` bits.

- `clk`  input  1  rising-edge clock.
- `resetn`  input  1  reset, synchronous, active-low.
- `flush`  input  1  synchronous clear of contents; keeps `overflow`.
- `in`  input  `WIDTH`  write data.
- `in_valid`  input  1  write request.
- `in_ready`  output  1  = !full; a write is accepted only when `in_valid && in_ready`.
- `out`  output  `WIDTH`  head entry (combinational from storage). Meaningful only when `out_valid`.
- `out_valid`  output  1  FIFO not empty.
- `out_ready`  input  1  consumer accept; a pop happens when `out_valid && out_ready`.
- `out_last`  output  1  exactly one entry stored (count == 1).
- `count`  output  `AW+1`  current occupancy, 0..`DEPTH`.
- `full`  output  1  count == `DEPTH`.
- `almost_full`  output  1  count ≥ `AFULL_THRESH`.
- `overflow`  output  1  sticky: set when `in_valid && !in_ready`; cleared only by reset.

## Operation
- Storage: `DEPTH` × `WIDTH` register array, not reset. Write pointer `wp` and read pointer `rp` are `AW+1` bits.
  - Index = low `AW` bits.
  - Empty when `wp == rp`. Full when the MSBs differ and the low bits are equal.
- Push (`in_valid && in_ready`): `mem[wp[AW-1:0]] <= in`, then `wp <= wp+1`. The pointer wraps naturally mod 2·`DEPTH`.
- Pop (`out_valid && out_ready`): `rp <= rp+1`.
- `count` is a register:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop, or when neither occurs.
  - It must always equal `wp − rp`, which the bench checks via assertion.
- `full`, `almost_full`, `out_valid` and `out_last` are decoded from the registered `count`/pointers. There are no combinational paths from `in_valid` or `out_ready` to any output.
- Priority, highest first: `!resetn` > `flush` > push/pop.
  - Reset: `wp=rp=0`, `count=0`, `overflow=0`.
  - Flush: `wp=rp=0`, `count=0`. Any push/pop in the same cycle is discarded. `overflow` is held.
- Rejected write (`in_valid` while `full`): data is dropped, pointers are unchanged, and `overflow` is set. This holds even if a pop occurs in the same cycle (no full-bypass).
- Empty with `in_valid` and `out_ready` both high: the push is accepted, no pop occurs (`out_valid` = 0), and the data appears at `out` next cycle.
- Full with a pop: `in_ready` rises the next cycle.

## Timing
- Reset values (cycle after `resetn` is sampled low):
  - `out_valid=0`, `in_ready=1`, `full=0`, `almost_full=0` (`AFULL_THRESH` ≥ 1), `out_last=0`, `count=0`, `overflow=0`.
  - `out` is X/don't-care.
- Write-to-read latency: 1 cycle. A word pushed at edge N is visible on `out` with `out_valid=1` after edge N.
- Read is fall-through: `out` shows the head with zero latency. After a pop at edge N, the next entry is on `out` after edge N.
- Sustained throughput is 1 push + 1 pop per cycle at any occupancy 1..`DEPTH`-1.
- Status flags update in the same cycle as `count`, one edge after the causing handshake.
- Reset or flush mid-stream: all in-flight entries are lost. `out_valid` drops after that edge.

## Test plan
- Reset and fill (DEPTH=16, WIDTH=13): reset, then push 0x0000..0x000F on consecutive cycles with `out_ready=0`.
  - `count` reaches 16.
  - `almost_full` is first high at count 14.
  - `full=1`, `in_ready=0`.
  - `out=0x0000`.
  - `overflow=0`.
- Drain and order: from full, hold `out_ready=1`.
  - `out` steps 0x0000..0x000F, one per cycle.
  - `out_last=1` exactly while `out=0x000F`.
  - `out_valid` falls after the 16th pop.
  - `count=0`.
- Simultaneous push/pop with wrap: stream 100 words (0x1000+i) with `in_valid=out_ready=1` after a 3-word preload.
  - `count` stays 3.
  - Output order is exact across pointer wrap.
  - No gaps in `out_valid`.
- Overflow: when full, assert `in_valid` with 0x1FFF while popping in the same cycle.
  - 0x1FFF is never output.
  - `overflow` goes to 1 and stays 1 through a subsequent `flush`.
  - It clears only on `resetn=0`.
- Flush priority: with 5 entries stored, assert `flush` together with a push and a pop.
  - The next cycle shows `count=0`, `out_valid=0`, `in_ready=1`.
  - A subsequent push of 0x0ABC gives `out=0x0ABC`, `out_last=1`.
- Empty edge and random: push on empty with `out_ready=1`.
  - No pop occurs in that cycle.
  - Data appears after 1 cycle.
  - Then run 10k cycles of random `in_valid`/`out_ready` against a scoreboard queue, with assertions: `count == wp−rp`, `full → !in_ready`, and `!out_valid → count==0`.
